// File: rtl/gf16_div_seq.sv
// Sequential GF(2^4) divider: Z = A / B computed as A * B^14 with three square-and-multiply steps.
// One operation in flight; result is held on the output until the consumer takes it.
module gf16_div_seq #(
    parameter logic [3:0] POLY = 4'b0011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] Z,
    output logic       div_zero
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and the payload is stable while valid is high and ready is low.

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    logic [3:0] acc;
    logic [3:0] pw;
    logic [1:0] cnt;
    logic       dz;
    logic [3:0] sq;
    logic [3:0] prod;

    // MSB-first shift-and-add; a carry out of bit 3 folds back in through POLY.
    function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            r = {r[2:0], 1'b0} ^ (r[3] ? POLY : 4'b0000);
            if (y[i]) begin
                r = r ^ x;
            end
        end
        return r;
    endfunction

    always_comb begin
        sq   = gf_mul(pw, pw);
        prod = gf_mul(acc, sq);
    end

    assign in_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= 4'b0000;
            pw        <= 4'b0000;
            cnt       <= 2'd0;
            dz        <= 1'b0;
            out_valid <= 1'b0;
            Z         <= 4'b0000;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        acc   <= A;
                        pw    <= B;
                        cnt   <= 2'd0;
                        dz    <= (B == 4'b0000);
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // pw walks B^2, B^4, B^8 while acc gathers A*B^2*B^4*B^8.
                    pw  <= sq;
                    acc <= prod;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd2) begin
                        state     <= S_DONE;
                        Z         <= prod;
                        div_zero  <= dz;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
